// File: rtl/sram_arb2_pkg.sv
// sram_arb2_pkg: shared port identifiers, request record and parity helper
// for the two-port arbitrated SRAM. mem_req_t is sized for the default
// sram_arb2 geometry (32-bit words, 1400 entries).
package sram_arb2_pkg;

    localparam int REQ_WIDTH = 32;
    localparam int REQ_DEPTH = 1400;
    localparam int REQ_AW    = $clog2(REQ_DEPTH);
    localparam int REQ_NB    = REQ_WIDTH / 8;

    typedef enum logic {
        PORT_IF   = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    typedef struct packed {
        logic                 we;
        logic [REQ_NB-1:0]    be;
        logic [REQ_AW-1:0]    addr;
        logic [REQ_WIDTH-1:0] wdata;
    } mem_req_t;

    // Even parity: the stored bit makes byte plus parity hold an even count of ones
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_arb2_rr.sv
// sram_arb2_rr: two-way arbiter for sram_arb2. Keeps the last granted port
// so that ties alternate; FIXED_PRIO=1 makes port 0 win every tie instead.
module sram_arb2_rr #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import sram_arb2_pkg::*;

    port_e rr_last;

    // Choose this cycle's winner; a tie goes to the port that did not win last time
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (FIXED_PRIO != 0 || rr_last == PORT_DATA) gnt = 2'b01;
                else                                         gnt = 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

    // Track the most recently granted port; reset favours port 0 on the first tie
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       rr_last <= PORT_DATA;
        else if (gnt[0]) rr_last <= PORT_IF;
        else if (gnt[1]) rr_last <= PORT_DATA;
    end

endmodule

// File: rtl/sram_arb2.sv
// sram_arb2: single-port synchronous SRAM shared by an instruction-fetch port
// (0) and a data port (1). Byte-enable writes, registered read data with a
// per-port valid strobe, and an out-of-range error flag.
// Optional per-byte even parity is enabled by defining SRAM_ARB2_PARITY_EN.
module sram_arb2 #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 1400,
    parameter  int FIXED_PRIO = 0,
    localparam int AW         = $clog2(DEPTH),
    localparam int NB         = WIDTH / 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [NB-1:0]    be0,
    input  logic [NB-1:0]    be1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic             perr
);
    import sram_arb2_pkg::*;

    mem_req_t         sel;
    logic             any_gnt;
    logic             in_range;
    logic [WIDTH-1:0] mem [DEPTH];

    sram_arb2_rr #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk  (clk),
        .nrst (nrst),
        .req  (req),
        .gnt  (gnt)
    );

    // Steer the granted port onto the array; addresses past DEPTH never touch storage
    always_comb begin
        if (gnt[1]) sel = '{we: we[1], be: be1, addr: addr1, wdata: wdata1};
        else        sel = '{we: we[0], be: be0, addr: addr0, wdata: wdata0};
        any_gnt  = |gnt;
        in_range = {1'b0, sel.addr} < (AW + 1)'(DEPTH);
    end

    // Byte-masked write; disabled bytes keep their old contents
    always_ff @(posedge clk) begin
        if (any_gnt && sel.we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (sel.be[i]) mem[sel.addr][8*i +: 8] <= sel.wdata[8*i +: 8];
            end
        end
    end

    // Response registers: rdata clears on writes and out-of-range reads, holds when idle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rvalid <= 2'b00;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= gnt;
            err    <= any_gnt && !in_range;
            if (any_gnt) begin
                if (sel.we || !in_range) rdata <= '0;
                else                     rdata <= mem[sel.addr];
            end
        end
    end

`ifdef SRAM_ARB2_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] par_calc;

    // Parity recomputed from the data currently stored at the selected address
    always_comb begin
        par_calc = '0;
        for (int i = 0; i < NB; i++) par_calc[i] = byte_parity(mem[sel.addr][8*i +: 8]);
    end

    // Parity bits follow exactly the bytes that are written
    always_ff @(posedge clk) begin
        if (any_gnt && sel.we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (sel.be[i]) par[sel.addr][i] <= byte_parity(sel.wdata[8*i +: 8]);
            end
        end
    end

    // Parity error accompanies rvalid for in-range reads only
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) perr <= 1'b0;
        else       perr <= any_gnt && !sel.we && in_range && (par_calc != par[sel.addr]);
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: directed table plus randomized traffic for sram_arb2, checked
// against a byte-array memory model. A second instance with FIXED_PRIO=1
// shares the inputs so its arbitration can be observed alongside.
module tb_sram_arb2;

    localparam int DEPTH = 1400;
    localparam int AW    = 11;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  req, we;
    logic [3:0]  be0, be1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt, rvalid, gnt_fp, rvalid_fp;
    logic [31:0] rdata, rdata_fp;
    logic        err, perr, err_fp, perr_fp;

    always #5 clk = ~clk;

    sram_arb2 #(.WIDTH(32), .DEPTH(DEPTH), .FIXED_PRIO(0)) dut (
        .clk(clk), .nrst(nrst), .req(req), .we(we), .be0(be0), .be1(be1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .perr(perr)
    );

    sram_arb2 #(.WIDTH(32), .DEPTH(DEPTH), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .nrst(nrst), .req(req), .we(we), .be0(be0), .be1(be1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt_fp), .rvalid(rvalid_fp), .rdata(rdata_fp), .err(err_fp), .perr(perr_fp)
    );

    typedef struct {
        logic [1:0]    req, we;
        logic [3:0]    be0, be1;
        logic [AW-1:0] a0, a1;
        logic [31:0]   wd0, wd1;
        logic [1:0]    e_gnt, e_rvalid;
        logic [31:0]   e_rdata;
        logic          e_err, e_perr;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    // Reference model: memory as bytes, last winner, and the visible read register
    logic [7:0]  mm [DEPTH][4];
    int          m_last;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] w,
                                input logic [3:0] b0, input logic [AW-1:0] a0,
                                input logic [31:0] d0, input logic [3:0] b1,
                                input logic [AW-1:0] a1, input logic [31:0] d1,
                                input logic [1:0] eg, input logic [31:0] ed,
                                input logic ee);
        vec_t v;
        v.req = rq; v.we = w;
        v.be0 = b0; v.a0 = a0; v.wd0 = d0;
        v.be1 = b1; v.a1 = a1; v.wd1 = d1;
        v.e_gnt = eg; v.e_rvalid = eg; v.e_rdata = ed; v.e_err = ee; v.e_perr = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_last  = 1;
        m_rdata = 32'h0;
    endtask

    // Apply one cycle of the arbitration and access rules to the model
    task automatic model(inout vec_t v);
        int            w;
        logic [AW-1:0] a;
        logic          wr;
        logic [3:0]    be;
        logic [31:0]   d;
        if (v.req == 2'b00)      w = -1;
        else if (v.req == 2'b01) w = 0;
        else if (v.req == 2'b10) w = 1;
        else                     w = 1 - m_last;
        if (w < 0) begin
            v.e_gnt = 2'b00;
            v.e_err = 1'b0;
        end else begin
            m_last  = w;
            v.e_gnt = (w == 1) ? 2'b10 : 2'b01;
            a  = (w == 1) ? v.a1  : v.a0;
            wr = v.we[w];
            be = (w == 1) ? v.be1 : v.be0;
            d  = (w == 1) ? v.wd1 : v.wd0;
            v.e_err = (int'(a) >= DEPTH);
            if (wr) begin
                if (int'(a) < DEPTH)
                    for (int b = 0; b < 4; b++) if (be[b]) mm[a][b] = d[8*b +: 8];
                m_rdata = 32'h0;
            end else if (int'(a) < DEPTH) begin
                m_rdata = {mm[a][3], mm[a][2], mm[a][1], mm[a][0]};
            end else begin
                m_rdata = 32'h0;
            end
        end
        v.e_rvalid = v.e_gnt;
        v.e_rdata  = m_rdata;
        v.e_perr   = 1'b0;
    endtask

    // Drive one vector at the falling edge, check the grant, then the response
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        req = v.req; we = v.we;
        be0 = v.be0; addr0 = v.a0; wdata0 = v.wd0;
        be1 = v.be1; addr1 = v.a1; wdata1 = v.wd1;
        #1;
        chk({tag, " gnt"}, 32'(gnt), 32'(v.e_gnt));
        chk({tag, " gnt_fixed"}, 32'(gnt_fp), (v.req == 2'b11) ? 32'd1 : 32'(v.req));
        @(posedge clk);
        #1;
        chk({tag, " rvalid"}, 32'(rvalid), 32'(v.e_rvalid));
        chk({tag, " rdata"}, rdata, v.e_rdata);
        chk({tag, " err"}, 32'(err), 32'(v.e_err));
        chk({tag, " perr"}, 32'(perr), 32'(v.e_perr));
        req = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req  = 2'b00;
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
    endtask

    vec_t tbl [17];

    initial begin
        vec_t          v;
        logic [AW-1:0] pa [2];
        logic [31:0]   pd [2];
        logic [3:0]    pbe [2];
        logic          pw [2];
        logic          has [2];
        int            r;

        nrst = 1'b0; req = 2'b00; we = 2'b00;
        be0 = 4'h0; be1 = 4'h0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        model_reset();

        // Reset state, then a request while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(negedge clk);
        req = 2'b01; addr0 = 11'd1; we = 2'b00;
        @(posedge clk);
        #1;
        chk("in-reset rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        req = 2'b00; nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset rvalid", 32'(rvalid), 32'd0);

        // Reset asserted while a read grant is in flight
        @(negedge clk);
        req = 2'b01; we = 2'b00; addr0 = 11'd1;
        #1;
        chk("mid-read gnt", 32'(gnt), 32'd1);
        #2 nrst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-read rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        req = 2'b00; nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-read rvalid after release", 32'(rvalid), 32'd0);
        chk("mid-read rdata after release", rdata, 32'd0);
        model_reset();

        // Known contents at the low and high ends of the array
        for (int i = 0; i < 20; i++) begin
            logic [AW-1:0] a;
            a = (i < 16) ? AW'(i) : AW'(DEPTH - 20 + i);
            v = mk(2'b01, 2'b01, 4'hF, a, 32'hC0DE0000 | 32'(a), 4'h0, '0, 32'h0,
                   2'b00, 32'h0, 1'b0);
            model(v);
            apply(v, $sformatf("init[%0d]", i));
        end

        do_reset();

        tbl[0]  = mk(2'b10, 2'b10, 4'h0, 11'd0, 32'h0, 4'hF, 11'd5, 32'hDEADBEEF, 2'b10, 32'h0, 1'b0);
        tbl[1]  = mk(2'b10, 2'b10, 4'h0, 11'd0, 32'h0, 4'h1, 11'd5, 32'h000000AA, 2'b10, 32'h0, 1'b0);
        tbl[2]  = mk(2'b10, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd5, 32'h0, 2'b10, 32'hDEADBEAA, 1'b0);
        tbl[3]  = mk(2'b11, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd5, 32'h0, 2'b01, 32'hC0DE0000, 1'b0);
        tbl[4]  = mk(2'b11, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd5, 32'h0, 2'b10, 32'hDEADBEAA, 1'b0);
        tbl[5]  = mk(2'b11, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd5, 32'h0, 2'b01, 32'hC0DE0000, 1'b0);
        tbl[6]  = mk(2'b11, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd5, 32'h0, 2'b10, 32'hDEADBEAA, 1'b0);
        tbl[7]  = mk(2'b00, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd0, 32'h0, 2'b00, 32'hDEADBEAA, 1'b0);
        tbl[8]  = mk(2'b01, 2'b01, 4'hF, 11'd7, 32'h12345678, 4'h0, 11'd0, 32'h0, 2'b01, 32'h0, 1'b0);
        tbl[9]  = mk(2'b01, 2'b00, 4'h0, 11'd7, 32'h0, 4'h0, 11'd0, 32'h0, 2'b01, 32'h12345678, 1'b0);
        tbl[10] = mk(2'b10, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd1400, 32'h0, 2'b10, 32'h0, 1'b1);
        tbl[11] = mk(2'b01, 2'b01, 4'hF, 11'd1400, 32'hFFFFFFFF, 4'h0, 11'd0, 32'h0, 2'b01, 32'h0, 1'b1);
        tbl[12] = mk(2'b10, 2'b10, 4'h0, 11'd0, 32'h0, 4'hF, 11'd1400, 32'hFFFFFFFF, 2'b10, 32'h0, 1'b1);
        tbl[13] = mk(2'b01, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd0, 32'h0, 2'b01, 32'hC0DE0000, 1'b0);
        tbl[14] = mk(2'b10, 2'b00, 4'h0, 11'd0, 32'h0, 4'h0, 11'd1399, 32'h0, 2'b10, 32'hC0DE0577, 1'b0);
        tbl[15] = mk(2'b01, 2'b01, 4'h0, 11'd7, 32'hFFFFFFFF, 4'h0, 11'd0, 32'h0, 2'b01, 32'h0, 1'b0);
        tbl[16] = mk(2'b01, 2'b00, 4'h0, 11'd7, 32'h0, 4'h0, 11'd0, 32'h0, 2'b01, 32'h12345678, 1'b0);

        for (int i = 0; i < 17; i++) begin
            v = tbl[i];
            model(v);
            apply(tbl[i], $sformatf("table[%0d]", i));
        end

        // Random traffic; an ungranted request stays unchanged until it wins
        has[0] = 1'b0; has[1] = 1'b0;
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!has[p] && $urandom_range(0, 9) < 6) begin
                    has[p] = 1'b1;
                    pw[p]  = 1'($urandom_range(0, 1));
                    pbe[p] = 4'($urandom_range(0, 15));
                    pd[p]  = $urandom;
                    r = $urandom_range(0, 9);
                    if (r < 6)      pa[p] = AW'($urandom_range(0, 15));
                    else if (r < 8) pa[p] = AW'($urandom_range(DEPTH - 4, DEPTH - 1));
                    else            pa[p] = AW'($urandom_range(DEPTH, 2047));
                end
            end
            v = mk({has[1], has[0]}, {pw[1], pw[0]}, pbe[0], pa[0], pd[0],
                   pbe[1], pa[1], pd[1], 2'b00, 32'h0, 1'b0);
            model(v);
            apply(v, $sformatf("rand[%0d]", n));
            if (v.e_gnt[0]) has[0] = 1'b0;
            if (v.e_gnt[1]) has[1] = 1'b0;
        end

`ifdef SRAM_ARB2_PARITY_EN
        // Corrupt one stored bit behind the parity, then repair it with a full write
        @(negedge clk);
        dut.mem[3] = dut.mem[3] ^ 32'h0000_0100;
        mm[3][1]   = mm[3][1] ^ 8'h01;
        v = mk(2'b01, 2'b00, 4'h0, 11'd3, 32'h0, 4'h0, 11'd0, 32'h0, 2'b00, 32'h0, 1'b0);
        model(v);
        v.e_perr = 1'b1;
        apply(v, "parity corrupt read");
        v = mk(2'b01, 2'b01, 4'hF, 11'd3, 32'h55AA55AA, 4'h0, 11'd0, 32'h0, 2'b00, 32'h0, 1'b0);
        model(v);
        apply(v, "parity rewrite");
        v = mk(2'b01, 2'b00, 4'h0, 11'd3, 32'h0, 4'h0, 11'd0, 32'h0, 2'b00, 32'h0, 1'b0);
        model(v);
        apply(v, "parity clean read");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
